// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the MEM stage: load/store op encodings,
// address-exception codes and the default data-memory size.
package mips_pkg;

  localparam int unsigned DM_BYTES_DEFAULT = 12288;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LW   = 4'd1,
    MEM_OP_LH   = 4'd2,
    MEM_OP_LHU  = 4'd3,
    MEM_OP_LB   = 4'd4,
    MEM_OP_LBU  = 4'd5,
    MEM_OP_SW   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SB   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_ADEL = 2'd1,
    EXC_ADES = 2'd2
  } exc_e;

  function automatic logic is_load_op(input logic [3:0] op);
    return op inside {MEM_OP_LW, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LB, MEM_OP_LBU};
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return op inside {MEM_OP_SW, MEM_OP_SH, MEM_OP_SB};
  endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/half of the data-memory word and sign- or
// zero-extends it according to the load op. Purely combinational.
module load_extender
  import mips_pkg::*;
(
  input  logic [3:0]  mem_op,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] read_data,
  output logic [31:0] result
);

  logic [15:0] half;
  logic [7:0]  byte_val;

  always_comb begin
    half     = byte_sel[1] ? read_data[31:16] : read_data[15:0];
    byte_val = read_data[{byte_sel, 3'b000} +: 8];
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    result   = '0;
    case (mem_op)
      MEM_OP_LW:  result = read_data;
      MEM_OP_LH:  result = {{16{half[15]}}, half};
      MEM_OP_LHU: result = {16'h0000, half};
      MEM_OP_LB:  result = {{24{byte_val[7]}}, byte_val};
      MEM_OP_LBU: result = {24'h000000, byte_val};
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: data-memory address/enables/store lanes, load extension
// and the MEM/WB register. Define MEM_EXC_EN to enable AdEL/AdES detection.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int unsigned DM_BYTES = DM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  mem_op,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        stall,
  input  logic        kill,
  input  logic [31:0] dm_read_data,
  output logic [3:0]  dm_write_enable,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_write_data,
  output logic [31:0] dm_pc,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_load_data,
  output logic        wb_is_load,
  output logic [1:0]  wb_exc,
  output logic [31:0] wb_bad_addr
);

  logic        is_load;
  logic        is_store;
  logic        exc_now;
  logic        write_fire;
  logic        store_done;
  logic [3:0]  lane_mask;
  logic [31:0] load_result;

  load_extender u_load_extender (
    .mem_op    (mem_op),
    .byte_sel  (addr[1:0]),
    .read_data (dm_read_data),
    .result    (load_result)
  );

  assign is_load  = is_load_op(mem_op);
  assign is_store = is_store_op(mem_op);
  assign dm_addr  = {addr[31:2], 2'b00};
  assign dm_pc    = pc;

`ifdef MEM_EXC_EN
  logic misaligned;
  logic out_of_range;
  exc_e exc_code;

  always_comb begin
    misaligned = 1'b0;
    case (mem_op)
      MEM_OP_LW, MEM_OP_SW:              misaligned = (addr[1:0] != 2'b00);
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:  misaligned = addr[0];
      default:                           misaligned = 1'b0;
    endcase
    out_of_range = (addr >= 32'(DM_BYTES));
    exc_now      = (is_load | is_store) & (misaligned | out_of_range);
    exc_code     = !exc_now ? EXC_NONE : (is_store ? EXC_ADES : EXC_ADEL);
  end
`else
  assign exc_now = 1'b0;
`endif

  always_comb begin
    dm_write_data = '0;
    lane_mask     = '0;
    case (mem_op)
      MEM_OP_SW: begin
        dm_write_data = store_data;
        lane_mask     = 4'b1111;
      end
      MEM_OP_SH: begin
        dm_write_data = {2{store_data[15:0]}};
        lane_mask     = addr[1] ? 4'b1100 : 4'b0011;
      end
      MEM_OP_SB: begin
        dm_write_data = {4{store_data[7:0]}};
        lane_mask     = 4'b0001 << addr[1:0];
      end
      default: ;
    endcase
  end

  // store_done keeps a stalled store from rewriting memory on every repeat cycle.
  assign write_fire      = in_valid & is_store & ~kill & ~exc_now & ~store_done;
  assign dm_write_enable = write_fire ? lane_mask : 4'b0000;

  // NOTE: state updates use non-blocking assignments; reset is synchronous and sampled on clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_done   <= 1'b0;
      wb_valid     <= 1'b0;
      wb_pc        <= '0;
      wb_load_data <= '0;
      wb_is_load   <= 1'b0;
    end else begin
      store_done <= stall & (store_done | write_fire);
      if (stall) begin
        // MEM/WB holds while the MEM instruction repeats.
      end else if (kill | ~in_valid) begin
        wb_valid     <= 1'b0;
        wb_pc        <= '0;
        wb_load_data <= '0;
        wb_is_load   <= 1'b0;
      end else begin
        wb_valid     <= 1'b1;
        wb_pc        <= pc;
        wb_load_data <= is_load ? load_result : '0;
        wb_is_load   <= is_load;
      end
    end
  end

`ifdef MEM_EXC_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_exc      <= EXC_NONE;
      wb_bad_addr <= '0;
    end else if (stall) begin
      wb_exc      <= wb_exc;
      wb_bad_addr <= wb_bad_addr;
    end else if (kill | ~in_valid) begin
      wb_exc      <= EXC_NONE;
      wb_bad_addr <= '0;
    end else begin
      wb_exc      <= exc_code;
      wb_bad_addr <= exc_now ? addr : '0;
    end
  end
`else
  assign wb_exc      = EXC_NONE;
  assign wb_bad_addr = '0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// stall/reset sequences and randomized traffic against a lane-arithmetic model.
module tb_mem_access_unit;

`ifdef MEM_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  mem_op;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        kill;
  logic [31:0] dm_read_data;
  logic [3:0]  dm_write_enable;
  logic [31:0] dm_addr;
  logic [31:0] dm_write_data;
  logic [31:0] dm_pc;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_load_data;
  logic        wb_is_load;
  logic [1:0]  wb_exc;
  logic [31:0] wb_bad_addr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .mem_op          (mem_op),
    .pc              (pc),
    .addr            (addr),
    .store_data      (store_data),
    .stall           (stall),
    .kill            (kill),
    .dm_read_data    (dm_read_data),
    .dm_write_enable (dm_write_enable),
    .dm_addr         (dm_addr),
    .dm_write_data   (dm_write_data),
    .dm_pc           (dm_pc),
    .wb_valid        (wb_valid),
    .wb_pc           (wb_pc),
    .wb_load_data    (wb_load_data),
    .wb_is_load      (wb_is_load),
    .wb_exc          (wb_exc),
    .wb_bad_addr     (wb_bad_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic st, input logic k,
                       input logic [31:0] rd, input logic [31:0] p);
    in_valid = v; mem_op = op; addr = a; store_data = sd;
    stall = st; kill = k; dm_read_data = rd; pc = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic v, input logic [31:0] p,
                          input logic [31:0] ld, input logic il,
                          input logic [1:0] ex, input logic [31:0] bad);
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
    check({tag, ".wb_pc"}, wb_pc, p);
    check({tag, ".wb_load_data"}, wb_load_data, ld);
    check({tag, ".wb_is_load"}, 32'(wb_is_load), 32'(il));
    check({tag, ".wb_exc"}, 32'(wb_exc), 32'(ex));
    check({tag, ".wb_bad_addr"}, wb_bad_addr, bad);
  endtask

  // Reference model: an access is `size` bytes wide, placed at the lane
  // offset rounded down to its size; stores replicate their low bytes.
  typedef struct {
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [1:0]  exc;
    logic [31:0] ld;
    logic        is_ld;
    logic        is_st;
  } model_t;

  function automatic model_t ref_model(input int op, input logic [31:0] a,
                                       input logic [31:0] sd, input logic [31:0] rd);
    model_t m;
    int size;
    bit sgn;
    int off;
    m = '{we: 4'h0, wdata: 32'h0, exc: 2'd0, ld: 32'h0, is_ld: 1'b0, is_st: 1'b0};
    sgn = 1'b0;
    case (op)
      1: begin size = 4; m.is_ld = 1'b1; end
      2: begin size = 2; m.is_ld = 1'b1; sgn = 1'b1; end
      3: begin size = 2; m.is_ld = 1'b1; end
      4: begin size = 1; m.is_ld = 1'b1; sgn = 1'b1; end
      5: begin size = 1; m.is_ld = 1'b1; end
      6: begin size = 4; m.is_st = 1'b1; end
      7: begin size = 2; m.is_st = 1'b1; end
      8: begin size = 1; m.is_st = 1'b1; end
      default: return m;
    endcase
    off = int'(((a % 4) / size) * size);
    if (m.is_st) begin
      m.we = 4'((1 << size) - 1) << off;
      for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
    end else begin
      m.ld = rd >> (8 * off);
      if (size < 4) begin
        m.ld = m.ld & ((32'h1 << (8 * size)) - 1);
        if (sgn && m.ld[8*size-1]) m.ld = m.ld | ~((32'h1 << (8 * size)) - 1);
      end
    end
    if (EXC_EN && (((a % size) != 0) || (a >= 32'd12288)))
      m.exc = m.is_st ? 2'd2 : 2'd1;
    return m;
  endfunction

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] sd;
    logic        k;
    logic [31:0] rd;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic        exp_wb_valid;
    logic [31:0] exp_ld;
    logic        exp_is_ld;
    logic [1:0]  exp_exc;
    logic [31:0] exp_bad;
  } vec_t;

  vec_t vecs[13];

  typedef struct {
    logic        v;
    logic [31:0] p;
    logic [31:0] ld;
    logic        il;
    logic [1:0]  ex;
    logic [31:0] bad;
  } wb_t;

  initial begin : main
    wb_t    exp_wb;
    model_t m;
    logic   wrote;
    logic   fire;
    logic [3:0] exp_we;

    vecs[0]  = '{1, 4'd8, 32'h5,    32'h1234_56AB, 0, 32'h0,         4'b0010, 32'hABAB_ABAB, 1, 32'h0,         0, 2'd0, 32'h0};
    vecs[1]  = '{1, 4'd5, 32'h5,    32'h0,         0, 32'h0000_AB00, 4'b0000, 32'h0,         1, 32'h0000_00AB, 1, 2'd0, 32'h0};
    vecs[2]  = '{1, 4'd4, 32'h5,    32'h0,         0, 32'h0000_AB00, 4'b0000, 32'h0,         1, 32'hFFFF_FFAB, 1, 2'd0, 32'h0};
    vecs[3]  = '{1, 4'd2, 32'h2,    32'h0,         0, 32'h8001_7FFF, 4'b0000, 32'h0,         1, 32'hFFFF_8001, 1, 2'd0, 32'h0};
    vecs[4]  = '{1, 4'd3, 32'h2,    32'h0,         0, 32'h8001_7FFF, 4'b0000, 32'h0,         1, 32'h0000_8001, 1, 2'd0, 32'h0};
    vecs[5]  = '{1, 4'd1, 32'h6,    32'h0,         0, 32'hDEAD_BEEF, 4'b0000, 32'h0,         1, 32'hDEAD_BEEF, 1,
                 EXC_EN ? 2'd1 : 2'd0, EXC_EN ? 32'h6 : 32'h0};
    vecs[6]  = '{1, 4'd7, 32'h3000, 32'hCAFE_1234, 0, 32'h0,         EXC_EN ? 4'b0000 : 4'b0011, 32'h1234_1234, 1, 32'h0, 0,
                 EXC_EN ? 2'd2 : 2'd0, EXC_EN ? 32'h3000 : 32'h0};
    vecs[7]  = '{1, 4'd6, 32'h20,   32'h5555_AAAA, 1, 32'h0,         4'b0000, 32'h5555_AAAA, 0, 32'h0,         0, 2'd0, 32'h0};
    vecs[8]  = '{0, 4'd1, 32'h40,   32'h0,         0, 32'h1111_1111, 4'b0000, 32'h0,         0, 32'h0,         0, 2'd0, 32'h0};
    vecs[9]  = '{1, 4'd8, 32'h3,    32'h0000_0077, 0, 32'h0,         4'b1000, 32'h7777_7777, 1, 32'h0,         0, 2'd0, 32'h0};
    vecs[10] = '{1, 4'd1, 32'h2FFC, 32'h0,         0, 32'h1234_5678, 4'b0000, 32'h0,         1, 32'h1234_5678, 1, 2'd0, 32'h0};
    vecs[11] = '{1, 4'd4, 32'h2FFF, 32'h0,         0, 32'h8000_0000, 4'b0000, 32'h0,         1, 32'hFFFF_FF80, 1, 2'd0, 32'h0};
    vecs[12] = '{1, 4'd9, 32'h8,    32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 4'b0000, 32'h0,         1, 32'h0,         0, 2'd0, 32'h0};

    reset = 1'b1;
    drive(0, 4'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    step();
    step();
    check_wb("reset", 0, 32'h0, 32'h0, 0, 2'd0, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      logic [31:0] p;
      string tag;
      p = 32'h0040_0000 + 32'(4 * i);
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].sd, 0, vecs[i].k, vecs[i].rd, p);
      #1;
      check({tag, ".we"}, 32'(dm_write_enable), 32'(vecs[i].exp_we));
      if (vecs[i].op inside {4'd6, 4'd7, 4'd8})
        check({tag, ".wdata"}, dm_write_data, vecs[i].exp_wdata);
      check({tag, ".dm_addr"}, dm_addr, {vecs[i].a[31:2], 2'b00});
      check({tag, ".dm_pc"}, dm_pc, p);
      step();
      check_wb(tag, vecs[i].exp_wb_valid, vecs[i].exp_wb_valid ? p : 32'h0,
               vecs[i].exp_ld, vecs[i].exp_is_ld, vecs[i].exp_exc, vecs[i].exp_bad);
    end

    // SW stalled three cycles: exactly one write; MEM/WB frozen on the prior load.
    drive(1, 4'd1, 32'h40, 32'h0, 0, 0, 32'h1122_3344, 32'h100);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1, 4'd6, 32'h10, 32'hA5A5_0F0F, 1, 0, 32'h0, 32'h104);
      #1;
      check($sformatf("stall%0d.we", c), 32'(dm_write_enable), (c == 0) ? 32'hF : 32'h0);
      step();
      check_wb($sformatf("stall%0d", c), 1, 32'h100, 32'h1122_3344, 1, 2'd0, 32'h0);
    end
    drive(1, 4'd6, 32'h10, 32'hA5A5_0F0F, 0, 0, 32'h0, 32'h104);
    #1;
    check("stall_release.we", 32'(dm_write_enable), 32'h0);
    step();
    check_wb("stall_release", 1, 32'h104, 32'h0, 0, 2'd0, 32'h0);

    // Reset in the middle of a stalled SW, then the SW is re-issued.
    drive(1, 4'd6, 32'h30, 32'h0BAD_F00D, 1, 0, 32'h0, 32'h200);
    #1;
    check("rst_seq.first_we", 32'(dm_write_enable), 32'hF);
    step();
    reset = 1'b1;
    step();
    check_wb("rst_seq", 0, 32'h0, 32'h0, 0, 2'd0, 32'h0);
    reset = 1'b0;
    drive(1, 4'd6, 32'h30, 32'h0BAD_F00D, 0, 0, 32'h0, 32'h200);
    #1;
    check("rst_seq.reissue_we", 32'(dm_write_enable), 32'hF);
    step();
    drive(0, 4'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    #1;
    check("rst_seq.after_we", 32'(dm_write_enable), 32'h0);
    step();

    // Randomized traffic; a stalled instruction is presented unchanged until released.
    wrote  = 1'b0;
    exp_wb = '{v: 1'b0, p: 32'h0, ld: 32'h0, il: 1'b0, ex: 2'd0, bad: 32'h0};
    for (int n = 0; n < 400; n++) begin
      if (!stall || n == 0) begin
        int sel;
        logic [31:0] a;
        sel = $urandom_range(0, 3);
        case (sel)
          0: a = $urandom_range(0, 64);
          1: a = $urandom_range(12280, 12300);
          2: a = $urandom;
          default: a = $urandom_range(0, 12287);
        endcase
        in_valid   = ($urandom_range(0, 9) < 8);
        mem_op     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        addr       = a;
        store_data = $urandom;
        pc         = $urandom & 32'hFFFF_FFFC;
      end
      stall        = ($urandom_range(0, 3) == 0);
      kill         = ($urandom_range(0, 6) == 0);
      dm_read_data = $urandom;
      m      = ref_model(int'(mem_op), addr, store_data, dm_read_data);
      fire   = in_valid && m.is_st && !kill && (m.exc == 2'd0) && !wrote;
      exp_we = fire ? m.we : 4'h0;
      #1;
      check($sformatf("rnd%0d.we", n), 32'(dm_write_enable), 32'(exp_we));
      if (m.is_st) check($sformatf("rnd%0d.wdata", n), dm_write_data, m.wdata);
      check($sformatf("rnd%0d.dm_addr", n), dm_addr, addr & 32'hFFFF_FFFC);
      if (!stall) begin
        if (kill || !in_valid)
          exp_wb = '{v: 1'b0, p: 32'h0, ld: 32'h0, il: 1'b0, ex: 2'd0, bad: 32'h0};
        else
          exp_wb = '{v: 1'b1, p: pc, ld: m.ld, il: m.is_ld, ex: m.exc,
                     bad: (m.exc != 2'd0) ? addr : 32'h0};
      end
      wrote = stall && (wrote || fire);
      step();
      check_wb($sformatf("rnd%0d", n), exp_wb.v, exp_wb.p, exp_wb.ld, exp_wb.il, exp_wb.ex, exp_wb.bad);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
